fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Instruction prefetch buffer between instruction memory and the IF/ID register.
//  Issues sequential 16-bit fetches over a req/ack handshake and buffers up to DEPTH instructions with their PC+2.
//  Presents the queue head to IF/ID.
//  A branch/jump redirect (the ID-stage flush with its JBPC target) clears the queue and restarts fetch.
// PARAMETERS
//  DEPTH     4       queue entries (power of two, >=2)
//  PC_W      16      PC / address width
//  INSTR_W   16      instruction width
//  RESET_PC  16'h0   fetch address after reset
// PORTS
//  clk          in   1        single clock; all state updates on rising edge
//  rst          in   1        synchronous, active-high reset
//  redirect     in   1        ID-stage branch taken / flush
//  redirect_pc  in   PC_W     new fetch target, valid with redirect
//  halt         in   1        level; freezes issue and dequeue
//  deq          in   1        IF/ID consumes head this cycle
//  imem_req     out  1        fetch request, held until imem_ack
//  imem_addr    out  PC_W     fetch address, stable while imem_req high
//  imem_ack     in   1        read data valid this cycle
//  imem_rdata   in   INSTR_W  fetched instruction
//  q_valid      out  1        head entry valid
//  q_instr      out  INSTR_W  head instruction
//  q_pc_next    out  PC_W     head address + 2 (feeds IF/ID PCIN)
//  q_count      out  clog2(DEPTH)+1   occupied entries
// BEHAVIOUR
//  Reset (rst high at an edge):
//   - state=FETCH; fetch_pc=RESET_PC; queue empty.
//   - imem_req=0, imem_addr=RESET_PC, q_valid=0, q_instr=0, q_pc_next=0, q_count=0.
//   - Takes priority over all inputs, including mid-request. An ack arriving after reset with no request outstanding is ignored.
//  FSM states:
//   - FETCH: no request outstanding; imem_req=0.
//     If !halt && !redirect && q_count<DEPTH: req_addr<=fetch_pc, go WAIT.
//     If halt (no redirect): go HALTED.
//   - WAIT: imem_req=1, imem_addr=req_addr. On imem_ack: enqueue {imem_rdata, req_addr+2}, fetch_pc<=req_addr+2, go FETCH.
//   - DISCARD: redirect arrived while a request was outstanding. imem_req stays 1 with the old req_addr. On ack: drop data, go FETCH.
//   - HALTED: imem_req=0. Return to FETCH when halt deasserts.
//  One request outstanding at most. An ack is accepted only in WAIT/DISCARD.
//  Enqueue occurs only from WAIT; occupancy is never exceeded because issue requires q_count<DEPTH.
//  Minimum latency: req issued cycle N+1 after FETCH decision, ack earliest N+2, q_valid the cycle after ack.
//   So empty-queue redirect -> q_valid takes 3 cycles minimum.
//  Dequeue: deq && q_valid && !halt pops head. deq when empty or halted is ignored.
//   Enqueue and dequeue in the same cycle leaves q_count unchanged.
//  Redirect (any state):
//   - Queue cleared and fetch_pc<=redirect_pc at the same edge.
//   - From WAIT without ack -> DISCARD. From WAIT with same-cycle ack -> data dropped, go FETCH.
//   - From FETCH/HALTED -> FETCH. In DISCARD: update fetch_pc, stay DISCARD.
//   - Redirect beats deq and enqueue in the same cycle.
//  Redirect with halt: redirect applied; halt handled next cycle.
//  halt does not cancel an outstanding request; its data still enqueues.
//  PC arithmetic: modulo 2^PC_W (0xFFFE+2 -> 0x0000); bit 0 of fetch addresses is always 0.
//  Outputs q_* are registered views of the head entry; q_instr/q_pc_next hold their last value when q_valid=0.
// STRUCTURE
//  Shared package pipeline_pkg:
//   - PC_W, INSTR_W, RESET_PC constants.
//   - fetch-state enum {FETCH, WAIT, DISCARD, HALTED}.
//   - PC increment constant 2.
//  Sub-module prefetch_fifo: storage plus rd/wr pointers (wrap at DEPTH), count, push/pop/clear.
//   The FSM and address logic stay in this module.
// TESTING
//  1. Reset, ack 1 cycle after each req, deq held 1 -> addrs 0,2,4,...; q_pc_next 2,4,6; q_valid first at cycle 3.
//  2. deq=0, ack immediately -> exactly 4 reqs (0..6), q_count=4, imem_req stays 0; one deq -> req addr 8 issued.
//  3. Req to 0x0004 outstanding, redirect_pc=0x0040, ack 3 cycles later -> queue empty, ack data dropped, next req addr 0x0040.
//  4. Redirect in the same cycle as ack and deq with q_count=2 -> q_count=0, data dropped, next req addr = redirect_pc.
//  5. halt asserted with req outstanding -> data enqueued, no new req, deq ignored; halt release -> fetch resumes at req_addr+2.
//  6. rst pulsed mid-WAIT, then stray ack -> all outputs at reset values, ack ignored, first req addr RESET_PC; fetch_pc 0xFFFE wraps to 0x0000.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-state type used by the prefetch queue.
package pipeline_pkg;

  localparam int              PC_W     = 16;
  localparam int              INSTR_W  = 16;
  localparam logic [15:0]     RESET_PC = 16'h0000;
  // Sequential fetch stride: one 16-bit instruction.
  localparam int              PC_INC   = 2;

  // FETCH:   idle, may issue a request next edge
  // WAIT:    request outstanding, data will be enqueued
  // DISCARD: request outstanding but a redirect made its data stale
  // HALTED:  frozen until halt drops
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HALTED  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch storage: circular buffer with wrapping pointers, occupancy count and
// a registered head view that holds its last value while the buffer is empty.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W-1:0]             head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  head_q;
  logic [W-1:0]  head_d;
  logic          push_ok;
  logic          pop_ok;

  // Clear wins over push/pop; a push into a full buffer is refused.
  assign push_ok = push_i && !clear_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i  && !clear_i && (count_q != CW'(0));

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_ok);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      count_q  <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Next head view: the entry that will sit at the head after this edge, or
  // the previous value when the buffer ends up empty.
  always_comb begin
    head_d = head_q;
    if (!clear_i) begin
      if ((count_q - CW'(pop_ok)) != CW'(0)) begin
        head_d = pop_ok ? mem_q[rd_ptr_q + AW'(1)] : mem_q[rd_ptr_q];
      end else if (push_ok) begin
        head_d = wdata_i;
      end
    end
  end

  // Registered head view.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else begin
      head_q <= head_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches over a req/ack
// handshake, buffers instructions with their PC+2, and flushes on redirect.
//
// Memory handshake: imem_req rises only from an idle state and stays high,
// with imem_addr stable, until the cycle in which imem_ack is sampled high;
// the transfer completes at that clock edge. At most one request is ever
// outstanding, and an ack is only honoured while a request is outstanding.
module fetch_prefetch_queue #(
  parameter int               DEPTH    = 4,
  parameter int               PC_W     = pipeline_pkg::PC_W,
  parameter int               INSTR_W  = pipeline_pkg::INSTR_W,
  parameter logic [PC_W-1:0]  RESET_PC = pipeline_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     halt,
  input  logic                     deq,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     q_valid,
  output logic [INSTR_W-1:0]       q_instr,
  output logic [PC_W-1:0]          q_pc_next,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [1:0]               dbg_state
);

  import pipeline_pkg::fetch_state_e;
  import pipeline_pkg::FETCH;
  import pipeline_pkg::WAIT;
  import pipeline_pkg::DISCARD;
  import pipeline_pkg::HALTED;
  import pipeline_pkg::PC_INC;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + PC_W;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   req_addr_q, req_addr_d;
  logic [PC_W-1:0]   req_addr_inc;
  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic              fifo_full;

  // Wraps modulo 2^PC_W.
  assign req_addr_inc = req_addr_q + PC_W'(PC_INC);
  assign fifo_full    = (fifo_count == CW'(DEPTH));

  // Fetch FSM and address next-state; redirect overrides every other input.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    if (redirect) begin
      fifo_clear = 1'b1;
      fetch_pc_d = redirect_pc & ~PC_W'(1);
      case (state_q)
        WAIT, DISCARD: state_d = imem_ack ? FETCH : DISCARD;
        default:       state_d = FETCH;
      endcase
    end else begin
      fifo_pop = deq && (fifo_count != CW'(0)) && !halt;
      case (state_q)
        FETCH: begin
          if (halt) begin
            state_d = HALTED;
          end else if (!fifo_full) begin
            req_addr_d = fetch_pc_q;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fifo_push  = 1'b1;
            fetch_pc_d = req_addr_inc;
            state_d    = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            state_d = FETCH;
          end
        end
        HALTED: begin
          if (!halt) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({imem_rdata, req_addr_inc}),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign imem_req  = (state_q == WAIT) || (state_q == DISCARD);
  assign imem_addr = req_addr_q;
  assign q_valid   = (fifo_count != CW'(0));
  assign q_instr   = fifo_head[EW-1:PC_W];
  assign q_pc_next = fifo_head[PC_W-1:0];
  assign q_count   = fifo_count;
  assign dbg_state = state_q;

endmodule
